// File: rtl/piezo_burst_gen.sv
// piezo_burst_gen: emits N complementary carrier periods on a piezo H-bridge,
// with dead-time between phases, a period counter and an optional start timestamp.
//
// Ports:
//   clock, reset      system clock, asynchronous active-high reset
//   start             burst request (accepted only in IDLE)
//   abort             synchronous stop request (wins over start)
//   burst_cycles      carrier periods to emit, latched on accepted start
//   time_cnt          free-running RTC count, captured on accepted start
//   busy, done        burst in progress / one-cycle completion pulse
//   piezo_p, piezo_n  bridge phases, registered, never high together
//   cycles_emitted    completed periods of the current or last burst
//   start_timestamp   time_cnt at accepted start
//
// Build option: define PIEZO_BURST_TIMESTAMP_EN to implement the
// start_timestamp register; otherwise it is tied to 0 and time_cnt is unused.

module piezo_burst_gen #(
    parameter int unsigned CLOCK_SPEED_HZ   = 50_000_000,
    parameter int unsigned CARRIER_HZ       = 40_000,
    parameter int unsigned DEAD_TIME_CYCLES = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        abort,
    input  logic [31:0] burst_cycles,
    input  logic [31:0] time_cnt,
    output logic        busy,
    output logic        done,
    output logic        piezo_p,
    output logic        piezo_n,
    output logic [31:0] cycles_emitted,
    output logic [31:0] start_timestamp
);

    localparam int unsigned HALF = CLOCK_SPEED_HZ / (2 * CARRIER_HZ);
    localparam int unsigned DRIVE_CYCLES = HALF - DEAD_TIME_CYCLES;
    localparam logic [31:0] DEAD_LAST = 32'(DEAD_TIME_CYCLES) - 32'd1;
    localparam logic [31:0] DRIVE_LAST = 32'(DRIVE_CYCLES) - 32'd1;
    // A zero dead-time skips the DEAD_* states entirely.
    localparam bit HAS_DEAD = (DEAD_TIME_CYCLES != 0);

    typedef enum logic [2:0] {
        IDLE,
        DEAD_P,
        DRIVE_P,
        DEAD_N,
        DRIVE_N,
        FINISH
    } state_t;

    state_t      state_q;
    logic [31:0] phase_cnt_q;
    logic [31:0] target_q;
    logic [31:0] emitted_q;
    logic [31:0] emitted_d;
    logic        busy_q;
    logic        done_q;
    logic        p_q;
    logic        n_q;
    logic        accept;

    assign emitted_d = emitted_q + 32'd1;
    assign accept    = (state_q == IDLE) && start && !abort;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            phase_cnt_q <= '0;
            target_q    <= '0;
            emitted_q   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            p_q         <= 1'b0;
            n_q         <= 1'b0;
        end else if (abort && state_q != IDLE) begin
            // Abort keeps emitted_q: it already counts only finished periods.
            state_q     <= IDLE;
            phase_cnt_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            p_q         <= 1'b0;
            n_q         <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (accept) begin
                        target_q    <= burst_cycles;
                        emitted_q   <= '0;
                        phase_cnt_q <= '0;
                        if (burst_cycles == 32'd0) begin
                            state_q <= FINISH;
                            done_q  <= 1'b1;
                        end else if (HAS_DEAD) begin
                            state_q <= DEAD_P;
                            busy_q  <= 1'b1;
                        end else begin
                            state_q <= DRIVE_P;
                            busy_q  <= 1'b1;
                            p_q     <= 1'b1;
                        end
                    end
                end
                DEAD_P: begin
                    if (phase_cnt_q == DEAD_LAST) begin
                        phase_cnt_q <= '0;
                        state_q     <= DRIVE_P;
                        p_q         <= 1'b1;
                    end else begin
                        phase_cnt_q <= phase_cnt_q + 32'd1;
                    end
                end
                DRIVE_P: begin
                    if (phase_cnt_q == DRIVE_LAST) begin
                        phase_cnt_q <= '0;
                        p_q         <= 1'b0;
                        if (HAS_DEAD) begin
                            state_q <= DEAD_N;
                        end else begin
                            state_q <= DRIVE_N;
                            n_q     <= 1'b1;
                        end
                    end else begin
                        phase_cnt_q <= phase_cnt_q + 32'd1;
                    end
                end
                DEAD_N: begin
                    if (phase_cnt_q == DEAD_LAST) begin
                        phase_cnt_q <= '0;
                        state_q     <= DRIVE_N;
                        n_q         <= 1'b1;
                    end else begin
                        phase_cnt_q <= phase_cnt_q + 32'd1;
                    end
                end
                DRIVE_N: begin
                    if (phase_cnt_q == DRIVE_LAST) begin
                        phase_cnt_q <= '0;
                        n_q         <= 1'b0;
                        emitted_q   <= emitted_d;
                        // Equality stops the burst before the counter can wrap.
                        if (emitted_d == target_q) begin
                            state_q <= FINISH;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else if (HAS_DEAD) begin
                            state_q <= DEAD_P;
                        end else begin
                            state_q <= DRIVE_P;
                            p_q     <= 1'b1;
                        end
                    end else begin
                        phase_cnt_q <= phase_cnt_q + 32'd1;
                    end
                end
                FINISH: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

`ifdef PIEZO_BURST_TIMESTAMP_EN
    logic [31:0] ts_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ts_q <= '0;
        end else if (accept) begin
            ts_q <= time_cnt;
        end
    end

    assign start_timestamp = ts_q;
`else
    logic unused_time_cnt;

    assign unused_time_cnt = ^time_cnt;
    assign start_timestamp = 32'd0;
`endif

    assign busy           = busy_q;
    assign done           = done_q;
    assign piezo_p        = p_q;
    assign piezo_n        = n_q;
    assign cycles_emitted = emitted_q;

endmodule

// File: tb/tb_piezo_burst_gen.sv
// Testbench for piezo_burst_gen: scenario tasks compared cycle by cycle
// against an arithmetic model of the burst waveform.

module tb_piezo_burst_gen;

    localparam int HALF = 50_000_000 / (2 * 40_000);
    localparam int DT   = 4;
    localparam int PER  = 2 * HALF;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic        abort;
    logic [31:0] burst_cycles;
    logic [31:0] time_cnt;
    logic        busy;
    logic        done;
    logic        piezo_p;
    logic        piezo_n;
    logic [31:0] cycles_emitted;
    logic [31:0] start_timestamp;

    int checks = 0;
    int errors = 0;

    piezo_burst_gen dut (
        .clock           (clock),
        .reset           (reset),
        .start           (start),
        .abort           (abort),
        .burst_cycles    (burst_cycles),
        .time_cnt        (time_cnt),
        .busy            (busy),
        .done            (done),
        .piezo_p         (piezo_p),
        .piezo_n         (piezo_n),
        .cycles_emitted  (cycles_emitted),
        .start_timestamp (start_timestamp)
    );

    always #5 clock = ~clock;

    // Expected {busy, done, p, n, emitted} in cycle t after the accepting
    // edge, for a burst of n periods aborted at edge ka (0 = never).
    function automatic logic [35:0] model(int t, int n, int ka);
        logic b, d, p, q;
        int   e, pos, last;
        last = PER * n;
        b = 0; d = 0; p = 0; q = 0; e = 0;
        if (ka > 0 && ka <= last && t > ka) begin
            e = (ka - 1) / PER;
        end else if (t <= last) begin
            b   = 1;
            e   = (t - 1) / PER;
            pos = (t - 1) % PER;
            p   = (pos >= DT) && (pos < HALF);
            q   = (pos >= HALF + DT);
        end else begin
            e = n;
            d = (t == last + 1);
        end
        return {b, d, p, q, 32'(e)};
    endfunction

    function automatic logic [31:0] ts_exp(logic [31:0] v);
`ifdef PIEZO_BURST_TIMESTAMP_EN
        return v;
`else
        return 32'd0;
`endif
    endfunction

    always @(negedge clock) begin
        if (!reset) begin
            checks = checks + 1;
            if (piezo_p && piezo_n) begin
                errors = errors + 1;
                $display("FAIL overlap t=%0t p=%b n=%b req not both 1",
                         $time, piezo_p, piezo_n);
            end
        end
    end

    task automatic test_reset();
        reset = 1; start = 0; abort = 0;
        burst_cycles = 0; time_cnt = 0;
        #12;
        checks++;
        if ({busy, done, piezo_p, piezo_n, cycles_emitted, start_timestamp}
            !== 68'd0) begin
            errors++;
            $display("FAIL reset_vals got b%b d%b p%b n%b e%0d ts%h req 0",
                     busy, done, piezo_p, piezo_n, cycles_emitted,
                     start_timestamp);
        end
        @(negedge clock);
        reset = 0;
        @(negedge clock);
    endtask

    task automatic test_basic();
        int n = 3;
        logic [35:0] exp;
        logic [31:0] ts = $urandom;
        start = 1; burst_cycles = n; time_cnt = ts;
        @(posedge clock);
        #1 start = 0;
        for (int t = 1; t <= PER * n + 3; t++) begin
            @(negedge clock);
            time_cnt = $urandom;
            exp = model(t, n, 0);
            checks++;
            if ({busy, done, piezo_p, piezo_n, cycles_emitted} !== exp) begin
                errors++;
                $display("FAIL basic t=%0d got %h req %h", t,
                         {busy, done, piezo_p, piezo_n, cycles_emitted}, exp);
            end
        end
        checks++;
        if (start_timestamp !== ts_exp(ts)) begin
            errors++;
            $display("FAIL basic_ts got %h req %h", start_timestamp, ts_exp(ts));
        end
    endtask

    task automatic test_zero();
        logic [35:0] exp;
        start = 1; burst_cycles = 0; time_cnt = 32'hCAFE_0001;
        @(posedge clock);
        #1 start = 0;
        for (int t = 1; t <= 4; t++) begin
            @(negedge clock);
            exp = model(t, 0, 0);
            checks++;
            if ({busy, done, piezo_p, piezo_n, cycles_emitted} !== exp) begin
                errors++;
                $display("FAIL zero t=%0d got %h req %h", t,
                         {busy, done, piezo_p, piezo_n, cycles_emitted}, exp);
            end
        end
        checks++;
        if (start_timestamp !== ts_exp(32'hCAFE_0001)) begin
            errors++;
            $display("FAIL zero_ts got %h req %h", start_timestamp,
                     ts_exp(32'hCAFE_0001));
        end
    endtask

    task automatic test_abort();
        int n = 5;
        int ka = 1500;
        logic [35:0] exp;
        start = 1; burst_cycles = n;
        @(posedge clock);
        #1 start = 0;
        for (int t = 1; t <= ka + 20; t++) begin
            @(negedge clock);
            exp = model(t, n, ka);
            checks++;
            if ({busy, done, piezo_p, piezo_n, cycles_emitted} !== exp) begin
                errors++;
                $display("FAIL abort t=%0d got %h req %h", t,
                         {busy, done, piezo_p, piezo_n, cycles_emitted}, exp);
            end
            abort = (t == ka);
        end
        abort = 0;
    endtask

    task automatic test_ignored_start();
        int n = 2;
        logic [35:0] exp;
        start = 1; burst_cycles = n; time_cnt = 32'h0000_1234;
        @(posedge clock);
        #1 start = 0;
        for (int t = 1; t <= PER * n + 3; t++) begin
            @(negedge clock);
            exp = model(t, n, 0);
            checks++;
            if ({busy, done, piezo_p, piezo_n, cycles_emitted} !== exp) begin
                errors++;
                $display("FAIL ign_start t=%0d got %h req %h", t,
                         {busy, done, piezo_p, piezo_n, cycles_emitted}, exp);
            end
            start = (t == 1000);
            if (t == 1000) begin
                burst_cycles = 7;
                time_cnt = 32'h5555_AAAA;
            end
        end
        start = 0;
        checks++;
        if (start_timestamp !== ts_exp(32'h0000_1234)) begin
            errors++;
            $display("FAIL ts_1234 got %h req %h", start_timestamp,
                     ts_exp(32'h0000_1234));
        end
    endtask

    task automatic test_back_to_back();
        logic [35:0] exp;
        start = 1; burst_cycles = 1; time_cnt = 32'h1111_0000;
        @(posedge clock);
        #1 start = 0;
        for (int t = 1; t <= PER + 1; t++) begin
            @(negedge clock);
            exp = model(t, 1, 0);
            checks++;
            if ({busy, done, piezo_p, piezo_n, cycles_emitted} !== exp) begin
                errors++;
                $display("FAIL b2b_a t=%0d got %h req %h", t,
                         {busy, done, piezo_p, piezo_n, cycles_emitted}, exp);
            end
        end
        // Start held from the FINISH cycle: ignored there, taken in IDLE.
        start = 1; burst_cycles = 2; time_cnt = 32'h2222_0000;
        @(negedge clock);
        checks++;
        if ({busy, done, cycles_emitted} !== {2'b00, 32'd1}) begin
            errors++;
            $display("FAIL b2b_idle got b%b d%b e%0d req b0 d0 e1",
                     busy, done, cycles_emitted);
        end
        burst_cycles = 1; time_cnt = 32'h3333_0000;
        @(posedge clock);
        #1 start = 0;
        for (int t = 1; t <= PER + 2; t++) begin
            @(negedge clock);
            exp = model(t, 1, 0);
            checks++;
            if ({busy, done, piezo_p, piezo_n, cycles_emitted} !== exp) begin
                errors++;
                $display("FAIL b2b_b t=%0d got %h req %h", t,
                         {busy, done, piezo_p, piezo_n, cycles_emitted}, exp);
            end
        end
        checks++;
        if (start_timestamp !== ts_exp(32'h3333_0000)) begin
            errors++;
            $display("FAIL b2b_ts got %h req %h", start_timestamp,
                     ts_exp(32'h3333_0000));
        end
    endtask

    task automatic test_abort_with_start();
        start = 1; abort = 1; burst_cycles = 3;
        @(negedge clock);
        start = 0; abort = 0;
        @(negedge clock);
        checks++;
        if ({busy, done, piezo_p, piezo_n} !== 4'b0000) begin
            errors++;
            $display("FAIL abort_prio got b%b d%b p%b n%b req 0000",
                     busy, done, piezo_p, piezo_n);
        end
    endtask

    task automatic test_reset_mid();
        logic [35:0] exp;
        start = 1; burst_cycles = 3;
        @(posedge clock);
        #1 start = 0;
        for (int t = 1; t <= 100; t++) begin
            @(negedge clock);
            exp = model(t, 3, 0);
            checks++;
            if ({busy, done, piezo_p, piezo_n, cycles_emitted} !== exp) begin
                errors++;
                $display("FAIL rst_pre t=%0d got %h req %h", t,
                         {busy, done, piezo_p, piezo_n, cycles_emitted}, exp);
            end
        end
        #2 reset = 1;
        #1;
        checks++;
        if ({busy, piezo_p, piezo_n, done} !== 4'b0000) begin
            errors++;
            $display("FAIL rst_async got b%b p%b n%b d%b req 0000",
                     busy, piezo_p, piezo_n, done);
        end
        @(negedge clock);
        reset = 0;
        @(negedge clock);
        test_basic();
    endtask

    task automatic test_random();
        int n;
        int ka;
        logic [35:0] exp;
        logic [31:0] ts;
        for (int k = 0; k < 4; k++) begin
            n  = $urandom_range(1, 3);
            ka = ($urandom_range(0, 1) == 1) ? $urandom_range(1, PER * n) : 0;
            ts = $urandom;
            start = 1; burst_cycles = n; time_cnt = ts;
            @(posedge clock);
            #1 start = 0;
            for (int t = 1; t <= PER * n + 2; t++) begin
                @(negedge clock);
                time_cnt = $urandom;
                exp = model(t, n, ka);
                checks++;
                if ({busy, done, piezo_p, piezo_n, cycles_emitted} !== exp) begin
                    errors++;
                    $display("FAIL rand n=%0d ka=%0d t=%0d got %h req %h",
                             n, ka, t,
                             {busy, done, piezo_p, piezo_n, cycles_emitted}, exp);
                end
                abort = (t == ka);
                if (ka > 0 && t > ka + 2) break;
            end
            abort = 0;
            checks++;
            if (start_timestamp !== ts_exp(ts)) begin
                errors++;
                $display("FAIL rand_ts got %h req %h", start_timestamp,
                         ts_exp(ts));
            end
            @(negedge clock);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero();
        test_abort();
        test_ignored_start();
        test_back_to_back();
        test_abort_with_start();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
